// File: rtl/uart_pkg.sv
// Shared types and bit-timing helpers for the UART receive front end.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } rx_state_t;

  function automatic int unsigned calc_cpb(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned calc_half(input int unsigned clk_freq, input int unsigned baud);
    return calc_cpb(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Valid/ready byte stream from the UART receiver to the command decoder.
interface uart_rx_fifo_if
  import uart_pkg::*;
();
  logic [BYTE_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/rx_byte_fifo.sv
// Show-ahead byte FIFO; a push while full is taken only alongside a pop.
module rx_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] head,
  output logic              empty,
  output logic              full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small output FIFO and framing/overflow pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            uart_din,
  uart_rx_fifo_if.master  dout,
  output logic            frame_err,
  output logic            overflow
);

  localparam int unsigned CPB   = calc_cpb(CLK_FREQ, BAUD);
  localparam int unsigned HALF  = calc_half(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W = $clog2(CPB);

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              sync1_q, rx_s_q;
  logic              frame_err_q, frame_err_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, fifo_empty, fifo_full;

  // Both flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_din;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    data_d      = data_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d         = '0;
          data_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7) state_d = StStop;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      StStop: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d = '0;
          if (rx_s_q) begin
            push       = 1'b1;
            // A pop in the same cycle frees the slot the push needs.
            overflow_d = fifo_full & ~pop;
            state_d    = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        cnt_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign pop        = dout.valid & dout.ready;
  assign dout.valid = ~fifo_empty;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (data_q),
    .pop       (pop),
    .head      (dout.data),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, corner sequences, random frames.
module tb_uart_rx_fifo;
  localparam int unsigned CLK_FREQ = 160;
  localparam int unsigned BAUD     = 10;
  localparam int unsigned DEPTH    = 4;
  localparam int          CPB      = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_din = 1'b1;
  logic frame_err, overflow;

  uart_rx_fifo_if dout_if ();

  uart_rx_fifo #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_din  (uart_din),
    .dout      (dout_if),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt, ovf_cnt, both_cnt;
  int exp_ferr, exp_ovf, occ;
  bit ready_mode;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_push;
    int         exp_ferr;
  } vec_t;

  // Observer: everything the consumer accepts, plus pulse counts.
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_if.valid && dout_if.ready) rx_q.push_back(dout_if.data);
      if (frame_err) ferr_cnt++;
      if (overflow) ovf_cnt++;
      if (frame_err && overflow) both_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_cycles);
    uart_din = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_din = b[i];
      repeat (CPB) tick();
    end
    uart_din = stop_lvl;
    repeat (stop_cycles) tick();
    uart_din = 1'b1;
  endtask

  // Reference: bad stop -> one frame_err; good byte -> delivered if room, else one overflow.
  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) exp_ferr++;
    else if (ready_mode) exp_q.push_back(b);
    else if (occ < int'(DEPTH)) begin
      exp_q.push_back(b);
      occ++;
    end else exp_ovf++;
  endtask

  task automatic clear_obs();
    rx_q.delete();
    exp_q.delete();
    ferr_cnt = 0;
    ovf_cnt  = 0;
    exp_ferr = 0;
    exp_ovf  = 0;
    occ      = 0;
  endtask

  task automatic check_obs(input string tag);
    int n;
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_byte"}, {24'h0, rx_q[i]}, {24'h0, exp_q[i]});
    chk({tag, "_frame_err"}, ferr_cnt, exp_ferr);
    chk({tag, "_overflow"}, ovf_cnt, exp_ovf);
  endtask

  task automatic drain(input int n);
    dout_if.ready = 1'b1;
    ready_mode    = 1'b1;
    for (int i = 0; i < 200 && rx_q.size() < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, dout_if.valid, 0);
    chk({tag, "_data"}, dout_if.data, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    vec_t vecs [8];
    int lat, width;
    logic [7:0] b;
    bit ok;

    vecs[0] = '{8'h35, 1'b1, 1, 0};
    vecs[1] = '{8'hA5, 1'b1, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 0};
    vecs[4] = '{8'h0F, 1'b0, 0, 1};
    vecs[5] = '{8'h80, 1'b1, 1, 0};
    vecs[6] = '{8'h55, 1'b0, 0, 1};
    vecs[7] = '{8'h01, 1'b1, 1, 0};

    dout_if.ready = 1'b0;
    both_cnt = 0;
    clear_obs();
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) tick();

    // Single frame: latency from start edge and one-cycle valid.
    dout_if.ready = 1'b1;
    ready_mode    = 1'b1;
    clear_obs();
    model_frame(8'h35, 1'b1);
    lat = 0;
    width = 0;
    fork
      send_frame(8'h35, 1'b1, CPB);
      begin
        while (!dout_if.valid && lat < 200) begin
          @(negedge clk);
          lat++;
        end
        while (dout_if.valid && width < 10) begin
          @(negedge clk);
          width++;
        end
      end
    join
    repeat (10) tick();
    chk("single_latency_max", (lat <= 164), 1);
    chk("single_latency_min", (lat >= 150), 1);
    chk("single_valid_width", width, 1);
    check_obs("single");

    // Vector table, consumer always ready.
    foreach (vecs[i]) begin
      clear_obs();
      send_frame(vecs[i].data, vecs[i].stop_ok, CPB);
      repeat (20) tick();
      chk("vec_pushes", rx_q.size(), vecs[i].exp_push);
      if (vecs[i].exp_push > 0)
        chk("vec_data", (rx_q.size() > 0) ? {24'h0, rx_q[0]} : 32'hffff_ffff,
            {24'h0, vecs[i].data});
      chk("vec_frame_err", ferr_cnt, vecs[i].exp_ferr);
      chk("vec_overflow", ovf_cnt, 0);
    end

    // Short low glitch on the idle line.
    clear_obs();
    uart_din = 1'b0;
    repeat (3) tick();
    uart_din = 1'b1;
    repeat (40) tick();
    check_obs("glitch");
    model_frame(8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1, CPB);
    repeat (20) tick();
    check_obs("after_glitch");

    // Bad stop then line held low; no bogus frame may follow.
    clear_obs();
    model_frame(8'h0F, 1'b0);
    send_frame(8'h0F, 1'b0, CPB + 40);
    repeat (200) tick();
    check_obs("held_low");
    model_frame(8'h01, 1'b1);
    send_frame(8'h01, 1'b1, CPB);
    repeat (20) tick();
    check_obs("after_held_low");

    // Consumer stalled, five back-to-back frames.
    clear_obs();
    dout_if.ready = 1'b0;
    ready_mode    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'h10 + 8'(i);
      model_frame(b, 1'b1);
      send_frame(b, 1'b1, CPB);
    end
    repeat (20) tick();
    chk("stall_overflow", ovf_cnt, exp_ovf);
    chk("stall_valid", dout_if.valid, 1);
    chk("stall_no_pop", rx_q.size(), 0);
    drain(4);
    repeat (5) tick();
    check_obs("stall_drain");

    // Full FIFO, pop coinciding with the stop-sample edge of 0x55.
    clear_obs();
    dout_if.ready = 1'b0;
    ready_mode    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = 8'h20 + 8'(i);
      model_frame(b, 1'b1);
      send_frame(b, 1'b1, CPB);
    end
    repeat (10) tick();
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1, CPB);
      begin
        repeat (154) tick();
        dout_if.ready = 1'b1;
        tick();
        dout_if.ready = 1'b0;
      end
    join
    repeat (20) tick();
    chk("same_cycle_overflow", ovf_cnt, 0);
    chk("same_cycle_one_pop", rx_q.size(), 1);
    drain(5);
    repeat (5) tick();
    check_obs("same_cycle");

    // Reset in the middle of 0xC3, then a clean 0x3C.
    clear_obs();
    dout_if.ready = 1'b1;
    ready_mode    = 1'b1;
    fork
      send_frame(8'hC3, 1'b1, CPB);
      begin
        repeat (88) tick();
        rst = 1'b1;
        repeat (2) tick();
        check_reset_outputs("midframe_reset");
        repeat (26) tick();
        rst = 1'b0;
      end
    join
    repeat (20) tick();
    model_frame(8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1, CPB);
    repeat (20) tick();
    check_obs("after_reset");

    // Randomised frames against the reference model.
    clear_obs();
    for (int i = 0; i < 30; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      model_frame(b, ok);
      send_frame(b, ok, CPB);
      repeat ($urandom_range(2, 20)) tick();
    end
    repeat (20) tick();
    check_obs("random");

    chk("pulse_exclusive", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
